// File: rtl/fir_decim_fifo.sv
// Post-FIR decimator: drops pipeline warm-up samples, keeps every DECIM-th
// sample and buffers kept samples in a first-word-fall-through FIFO.
module fir_decim_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4,
  parameter int WARMUP = 14,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_en,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FW  = $clog2(DEPTH + 1);
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(DECIM - 1);
  localparam logic [FW-1:0]  FILL_MAX  = FW'(DEPTH);

  typedef enum logic {WARM, RUN} mode_t;
  localparam mode_t MODE_INIT = (WARMUP == 0) ? RUN : WARM;

  mode_t              r_mode;
  logic [WCW-1:0]     r_warm_cnt;
  logic [PHW-1:0]     r_phase;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [FW-1:0]      r_fill;
  logic               r_ovf;

  logic w_keep;
  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_drop;

  always_comb begin
    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    w_keep = 1'b0;
    w_full = (r_fill == FILL_MAX);
    w_pop  = m_valid && m_ready;
    if (r_mode == RUN && in_en && r_phase == '0) w_keep = 1'b1;
    w_push = w_keep && (!w_full || w_pop);
    w_drop = w_keep && w_full && !w_pop;
  end

  // Warm-up / decimation sequencing; RUN is left only through reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_mode     <= MODE_INIT;
      r_warm_cnt <= '0;
      r_phase    <= '0;
    end else if (in_en) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      case (r_mode)
        WARM: begin
          r_warm_cnt <= r_warm_cnt + WCW'(1);
          if (r_warm_cnt == WARM_LAST) begin
            r_mode  <= RUN;
            r_phase <= '0;
          end
        end
        RUN: r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PHW'(1);
        default: r_mode <= MODE_INIT;
      endcase
    end
  end

  // NOTE: sample storage is deliberately not reset; r_fill alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + FW'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - FW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign m_valid = (r_fill != '0);
  assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;
  assign fill    = r_fill;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo: a queue-based reference model decides
// kept/dropped samples; a negedge monitor checks every handshake in order.
module tb_fir_decim_fifo;

  localparam int DATA_W = 16;
  localparam int DECIM  = 4;
  localparam int WARMUP = 14;
  localparam int DEPTH  = 8;
  localparam int FW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [FW-1:0]     fill;
  logic              ovf;
  logic              ovf_clr;

  always #5 clk = ~clk;

  fir_decim_fifo #(
    .DATA_W(DATA_W), .DECIM(DECIM), .WARMUP(WARMUP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .din(din),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fill(fill), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] mdl_q[$];
  int                strobe_n;
  logic              mdl_ovf;
  bit                rand_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got data %0d expected no output at %0t", m_data, $time);
      end else begin
        check("m_data", 32'(m_data), 32'(sb_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit en, input bit rdy, input bit clr);
    logic [DATA_W-1:0] v;
    bit pop, keep, drop;
    v = rand_data ? DATA_W'($urandom) : DATA_W'(strobe_n);
    in_en   = en;
    din     = v;
    m_ready = rdy;
    ovf_clr = clr;
    pop  = (mdl_q.size() > 0) && rdy;
    keep = en && (strobe_n >= WARMUP) && (((strobe_n - WARMUP) % DECIM) == 0);
    drop = keep && (mdl_q.size() == DEPTH) && !pop;
    if (pop) void'(mdl_q.pop_front());
    if (keep && !drop) begin
      mdl_q.push_back(v);
      sb_q.push_back(v);
    end
    if (drop)     mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    if (en) strobe_n++;
    @(posedge clk);
    #1;
    check("fill", 32'(fill), 32'(mdl_q.size()));
    check("m_valid", 32'(m_valid), 32'(mdl_q.size() > 0));
    check("ovf", 32'(ovf), 32'(mdl_ovf));
    if (!m_valid) check("m_data_idle", 32'(m_data), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst_n   = 1'b1;
    in_en   = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    din     = '0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    mdl_q.delete();
    sb_q.delete();
    strobe_n = 0;
    mdl_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 4) cycle(1'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_en     = 1'b0;
    din       = '0;
    m_ready   = 1'b0;
    ovf_clr   = 1'b0;
    rand_data = 1'b0;
    @(posedge clk);
    #1;

    // Warm-up discard with a free-running consumer.
    do_reset();
    repeat (40) cycle(1'b1, 1'b1, 1'b0);
    drain();

    // Gapped strobes: keep points follow strobes, not clocks.
    do_reset();
    repeat (WARMUP) cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle(i[0] == 1'b0, 1'b1, 1'b0);
    drain();

    // Backpressure from reset: fill to DEPTH, then drop 46, then drain in order.
    do_reset();
    repeat (50) cycle(1'b1, 1'b0, 1'b0);
    check("bp_head", 32'(m_data), 32'd14);
    drain();

    // Full FIFO with push and pop on the same edge.
    do_reset();
    repeat (46) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("full_pp_head", 32'(m_data), 32'd18);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    drain();

    // ovf_clr coinciding with a drop, then a clear with no drop.
    do_reset();
    repeat (46) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    drain();

    // Reset with five samples buffered; warm-up restarts afterwards.
    do_reset();
    repeat (31) cycle(1'b1, 1'b0, 1'b0);
    check("pre_rst_fill", 32'(fill), 32'd5);
    do_reset();
    repeat (30) cycle(1'b1, 1'b1, 1'b0);
    drain();

    // Randomized traffic with random data.
    do_reset();
    rand_data = 1'b1;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
Downstream stage of the 9-tap pipelined FIR. It consumes the FIR's 16-bit output stream, which runs one sample per clock with no valid qualifier, and discards the pipeline warm-up samples after reset. It keeps every DECIM-th sample and buffers the kept samples in a small first-word-fall-through (FWFT) FIFO. Samples leave on a valid/ready interface, with sticky overflow reporting.

Parameters:
DATA_W, 16, sample width (matches FIR data_out)
DECIM, 4, decimation factor, >=1; 1 = keep every sample
WARMUP, 14, number of accepted input strobes discarded after reset (FIR fill + pipeline latency); 0 = no discard
DEPTH, 8, FIFO depth in samples, power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (block is in reset while rst_n=1)
in_en  in  1  input strobe; din is sampled on a rising clk edge only when in_en=1
din  in  DATA_W  signed sample from the FIR data_out
m_data  out  DATA_W  signed FIFO head sample; 0 when m_valid=0
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data this cycle
fill  out  $clog2(DEPTH+1)  number of samples held, 0..DEPTH
ovf  out  1  sticky flag: a kept sample was dropped because the FIFO was full
ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (rst_n=1, asynchronous): mode=WARM (mode=RUN if WARMUP=0), warm_cnt=0, phase=0, wr_ptr=rd_ptr=0, fill=0, m_valid=0, m_data=0, ovf=0.
- Reset applied mid-operation drops all FIFO contents immediately. The warm-up discard restarts after reset is released.
- State machine:
  - WARM: each in_en=1 cycle increments warm_cnt; din is discarded.
  - When in_en=1 and warm_cnt==WARMUP-1, move to RUN next cycle with phase=0.
  - in_en=0 holds all counters.
  - RUN is terminal until reset.
- Decimation (RUN only):
  - Each in_en=1 cycle advances phase 0..DECIM-1 with wrap to 0.
  - The sample is kept when phase==0 at that edge, so the first strobe in RUN is kept.
  - in_en=0 freezes phase.
- Push/pop rules:
  - push = keep and (fill<DEPTH or pop).
  - pop = m_valid and m_ready.
  - Push to a full FIFO succeeds only when a pop occurs in the same cycle; fill stays at DEPTH.
  - Push and pop in the same cycle at any fill leave fill unchanged.
  - Pop while empty has no effect.
- Overflow:
  - keep and fill==DEPTH and no pop: sample dropped, ovf<=1, phase still advances.
  - ovf_clr in the same cycle as a new drop: set wins, ovf stays 1.
- FWFT latency:
  - A kept sample written at edge k is visible on m_data/m_valid immediately after edge k if the FIFO was empty.
  - Otherwise it appears in FIFO order.
- m_data = mem[rd_ptr] when fill!=0, else 0. m_data must be stable while m_valid=1 and m_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fill is a separate counter, never derived from pointer difference.
- Arithmetic: data passes through unmodified, with no rescaling or sign change. All counters saturate or wrap exactly as stated above.
- No combinational path from m_ready to m_valid or m_data. m_ready affects only the next-state logic.

Test Plan:
Unless stated otherwise, all scenarios use DECIM=4, WARMUP=14, DEPTH=8, and din=n on the n-th in_en strobe after reset (n from 0).
1. Warm-up discard: in_en=1 continuously, m_ready=1 -> first m_valid carries 14, then 18, 22, 26. Nothing appears before strobe 14.
2. Gapped strobes: in_en toggles 1/0 in RUN -> kept values are still 14, 18, 22 (counted on strobes, not clocks). The fill/ready timing shifts accordingly.
3. Backpressure/overflow: m_ready=0 from reset with continuous in_en.
   - fill reaches 8 after sample 42; m_data holds 14 throughout.
   - Sample 46 is dropped and ovf=1.
   - Raising m_ready then drains 14..42 in order, with no 46.
4. Full with simultaneous push and pop: hold fill=8, assert m_ready for exactly the cycle sample 46 is kept -> 14 popped, 46 stored, fill stays 8, ovf stays 0.
5. ovf_clr vs set: pulse ovf_clr the same cycle as a drop -> ovf=1. Pulse ovf_clr on a later cycle with no drop -> ovf=0 next cycle.
6. Reset mid-run: with fill=5, assert rst_n=1 asynchronously -> m_valid, fill, ovf and m_data go to 0 without a clock edge. After release, 14 more strobes are discarded before the next output.
